// File: rtl/btn_debounce_pkg.sv
// Shared types and helpers for the multi-channel button debouncer.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        st_low       = 2'd0,
        st_wait_high = 2'd1,
        st_high      = 2'd2,
        st_wait_low  = 2'd3
    } btn_state_e;

    // Counter width for a counter that must hold values 0..n-1 (never below 1 bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounced button channel: 2-flop synchroniser, four-state debounce FSM,
// edge pulses and (with BTN_LONG_PRESS_EN defined) a saturating hold counter.
module btn_debounce_ch
    import btn_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
`ifdef BTN_LONG_PRESS_EN
    ,
    parameter int LONG_PRESS_CYCLES = 1000
`endif
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn,
    output logic       o_out,
    output logic       o_press,
    output logic       o_release,
    output logic       o_long_press,
    output btn_state_e o_state
);

    localparam logic [1:0] ST_LOW       = st_low;
    localparam logic [1:0] ST_WAIT_HIGH = st_wait_high;
    localparam logic [1:0] ST_HIGH      = st_high;
    localparam logic [1:0] ST_WAIT_LOW  = st_wait_low;

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    // The stored count tops out one below the acceptance value: the accepting
    // edge is the one whose increment would reach DEBOUNCE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic             r_press;
    logic             r_release;

    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_rise;
    logic             w_fall;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            ST_LOW: begin
                if (r_sync2) begin
                    w_next_state = ST_WAIT_HIGH;
                    w_next_cnt   = '0;
                end
            end
            ST_WAIT_HIGH: begin
                if (!r_sync2) begin
                    w_next_state = ST_LOW;
                    w_next_cnt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_next_state = ST_HIGH;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (!r_sync2) begin
                    w_next_state = ST_WAIT_LOW;
                    w_next_cnt   = '0;
                end
            end
            ST_WAIT_LOW: begin
                if (r_sync2) begin
                    w_next_state = ST_HIGH;
                    w_next_cnt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_next_state = ST_LOW;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_next_state = ST_LOW;
                w_next_cnt   = '0;
            end
        endcase
    end

    assign w_rise = (r_state == ST_WAIT_HIGH) && (w_next_state == ST_HIGH);
    assign w_fall = (r_state == ST_WAIT_LOW)  && (w_next_state == ST_LOW);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_state   <= ST_LOW;
            r_cnt     <= '0;
            r_out     <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            r_out     <= (w_next_state == ST_HIGH) || (w_next_state == ST_WAIT_LOW);
            r_press   <= w_rise;
            r_release <= w_fall;
        end
    end

    assign o_out     = r_out;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_state   = btn_state_e'(r_state);

`ifdef BTN_LONG_PRESS_EN
    localparam int                HOLD_W    = cnt_width(LONG_PRESS_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    logic [HOLD_W-1:0] r_hold;
    logic              r_long;

    // Hold count saturates at LONG_PRESS_CYCLES so the pulse fires once per press.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hold <= '0;
            r_long <= 1'b0;
        end else if (w_rise) begin
            r_hold <= '0;
            r_long <= 1'b0;
        end else if (((r_state == ST_HIGH) || (r_state == ST_WAIT_LOW)) && (r_hold != HOLD_MAX)) begin
            r_hold <= r_hold + HOLD_W'(1);
            r_long <= (r_hold == HOLD_LAST);
        end else begin
            r_long <= 1'b0;
        end
    end

    assign o_long_press = r_long;
`else
    assign o_long_press = 1'b0;
`endif

endmodule

// File: rtl/multi_btn_debounce.sv
// NUM_CH independent debounced button channels. Define BTN_LONG_PRESS_EN to
// enable per-channel long-press detection; otherwise long_press is tied low.
module multi_btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int NUM_CH            = 4,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int LONG_PRESS_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   btn,
    output logic [NUM_CH-1:0]   out,
    output logic [NUM_CH-1:0]   press,
    output logic [NUM_CH-1:0]   o_release,   // "release" is a reserved word
    output logic [NUM_CH-1:0]   long_press,
    output logic [2*NUM_CH-1:0] o_dbg_state
);

    if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
        $error("multi_btn_debounce: NUM_CH must be 1..32");
    end
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("multi_btn_debounce: DEBOUNCE_CYCLES must be 2..65535");
    end
    if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
        $error("multi_btn_debounce: LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        btn_state_e w_state;

        btn_debounce_ch #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES)
`ifdef BTN_LONG_PRESS_EN
            ,
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
`endif
        ) u_ch (
            .i_clk       (clk),
            .i_reset     (reset),
            .i_btn       (btn[i]),
            .o_out       (out[i]),
            .o_press     (press[i]),
            .o_release   (o_release[i]),
            .o_long_press(long_press[i]),
            .o_state     (w_state)
        );

        assign o_dbg_state[2*i +: 2] = w_state;
    end

endmodule

// File: tb/tb_multi_btn_debounce.sv
// Self-checking bench for multi_btn_debounce: directed button patterns, pulse
// events scoreboarded against an expected queue, levels checked at fixed edges.
module tb_multi_btn_debounce;

  localparam int NUM_CH = 4;
  localparam int DEB    = 4;
  localparam int LONG   = 20;
  localparam int W      = 40;

  localparam logic [1:0] K_PRESS = 2'd0;
  localparam logic [1:0] K_REL   = 2'd1;
  localparam logic [1:0] K_LONG  = 2'd2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NUM_CH-1:0]   btn = '0;
  logic [NUM_CH-1:0]   out;
  logic [NUM_CH-1:0]   press;
  logic [NUM_CH-1:0]   rel;
  logic [NUM_CH-1:0]   long_press;
  logic [2*NUM_CH-1:0] dbg_state;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_btn_debounce #(
    .NUM_CH(NUM_CH),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_PRESS_CYCLES(LONG)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn(btn),
    .out(out),
    .press(press),
    .o_release(rel),
    .long_press(long_press),
    .o_dbg_state(dbg_state)
  );

  // ---------------- helpers / driver tasks ----------------
  function automatic logic [W-1:0] mk_ev(input int at, input logic [1:0] kind, input int ch);
    logic [31:0] at_v;
    logic [5:0]  ch_v;
    at_v = at;
    ch_v = 6'(ch);
    return {at_v, kind, ch_v};
  endfunction

  task automatic expect_ev(input int at, input logic [1:0] kind, input int ch);
    exp_q.push_back(mk_ev(at, kind, ch));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_out"}, 32'(out), 32'd0);
    check({name, "_press"}, 32'(press), 32'd0);
    check({name, "_release"}, 32'(rel), 32'd0);
    check({name, "_long"}, 32'(long_press), 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] obs;
    logic [W-1:0] exp_ev;
    logic [NUM_CH-1:0] pulses [3];
    pulses[0] = press;
    pulses[1] = rel;
    pulses[2] = long_press;
    while (exp_q.size() > 0 && int'(exp_q[0][W-1:8]) < cyc) begin
      exp_ev = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event: expected cycle %0d kind %0d ch %0d not seen (now cycle %0d)",
               exp_ev[W-1:8], exp_ev[7:6], exp_ev[5:0], cyc);
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int k = 0; k < 3; k++) begin
        if (pulses[k][ch]) begin
          obs = mk_ev(cyc, 2'(k), ch);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got cycle %0d kind %0d ch %0d, expected none", cyc, k, ch);
          end else begin
            exp_ev = exp_q.pop_front();
            if (exp_ev !== obs) begin
              errors++;
              $display("FAIL event: got cycle %0d kind %0d ch %0d, expected cycle %0d kind %0d ch %0d",
                       cyc, k, ch, exp_ev[W-1:8], exp_ev[7:6], exp_ev[5:0]);
            end
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    int c1;
    logic [4:0] bounce;
    bounce = 5'b10101;

    reset = 1'b1;
    btn   = '0;
    tick(3);
    check_all_zero("reset");
    check("reset_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    tick(2);

    // Clean step on channel 0, held 50 cycles, then released.
    c0 = cyc;
    btn[0] = 1'b1;
    expect_ev(c0 + 6, K_PRESS, 0);
`ifdef BTN_LONG_PRESS_EN
    expect_ev(c0 + 6 + LONG, K_LONG, 0);
`endif
    tick(5);
    check("step_out_edge5", 32'(out), 32'h0);
    tick(1);
    check("step_out_edge6", 32'(out), 32'h1);
    tick(44);
    c1 = cyc;
    btn[0] = 1'b0;
    expect_ev(c1 + 6, K_REL, 0);
    tick(5);
    check("step_fall_edge5", 32'(out), 32'h1);
    tick(1);
    check("step_fall_edge6", 32'(out), 32'h0);
    tick(4);

    // Three-cycle pulse on channel 1 must be rejected.
    btn[1] = 1'b1;
    tick(3);
    btn[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("glitch_out", 32'(out), 32'h0);
    end

    // Bouncing press on channel 2: 1,0,1,0,1 then steady.
    c0 = cyc;
    for (int i = 0; i < 5; i++) begin
      btn[2] = bounce[4 - i];
      if (i < 4) tick(1);
    end
    expect_ev(c0 + 10, K_PRESS, 2);
    tick(5);
    check("bounce_out_before", 32'(out), 32'h0);
    tick(1);
    check("bounce_out_rise", 32'(out), 32'h4);
    tick(2);
    c1 = cyc;
    btn[2] = 1'b0;
    expect_ev(c1 + 6, K_REL, 2);
    tick(8);

    // Held channel 3 released cleanly.
    c0 = cyc;
    btn[3] = 1'b1;
    expect_ev(c0 + 6, K_PRESS, 3);
    tick(10);
    check("hold3_out", 32'(out), 32'h8);
    c1 = cyc;
    btn[3] = 1'b0;
    expect_ev(c1 + 6, K_REL, 3);
    tick(5);
    check("rel3_out_before", 32'(out), 32'h8);
    tick(1);
    check("rel3_out_fall", 32'(out), 32'h0);
    tick(3);

    // Reset during ST_WAIT_HIGH with btn[1] held.
    btn[1] = 1'b1;
    tick(3);
    check("wait_high_state", 32'(dbg_state[3:2]), 32'd1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_all_zero("mid_reset");
    end
    reset = 1'b0;
    c0 = cyc;
    expect_ev(c0 + 6, K_PRESS, 1);
    tick(5);
    check("post_reset_before", 32'(out), 32'h0);
    tick(1);
    check("post_reset_rise", 32'(out), 32'h2);
    c1 = cyc;
    btn[1] = 1'b0;
    expect_ev(c1 + 6, K_REL, 1);
    tick(10);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
